// File: rtl/stream_arb3.sv
// Three-source round-robin stream arbiter with a registered output stage.
// Define STREAM_ARB3_LOCK_EN to keep a granted source selected until its burst ends.
module stream_arb3 #(
    parameter int DWidth = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        valid_i,
    input  logic [DWidth-1:0] data0_i,
    input  logic [DWidth-1:0] data1_i,
    input  logic [DWidth-1:0] data2_i,
    input  logic [2:0]        last_i,
    output logic [2:0]        ready_o,
    output logic              valid_o,
    output logic [DWidth-1:0] data_o,
    output logic [1:0]        sel_o,
    output logic              last_o,
    input  logic              ready_i
);

    function automatic logic [1:0] inc3(input logic [1:0] p);
        logic [1:0] q;
        case (p)
            2'd0:    q = 2'd1;
            2'd1:    q = 2'd2;
            default: q = 2'd0;
        endcase
        return q;
    endfunction

`ifdef STREAM_ARB3_LOCK_EN
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_lock_src;
    logic [1:0] w_lock_src_nxt;
`endif

    logic [1:0]        r_ptr;
    logic [1:0]        w_ptr_nxt;
    logic [1:0]        w_cand1;
    logic [1:0]        w_cand2;
    logic              w_pick_vld;
    logic [1:0]        w_pick_idx;
    logic              w_load_en;
    logic              w_grant;
    logic [DWidth-1:0] w_data_sel;

    logic              r_valid;
    logic [DWidth-1:0] r_data;
    logic [1:0]        r_sel;
    logic              r_last;

    // Pick the first valid source starting at ptr, or the locked source mid-burst
    always_comb begin
        w_cand1    = inc3(r_ptr);
        w_cand2    = inc3(w_cand1);
        w_pick_vld = 1'b0;
        w_pick_idx = r_ptr;
`ifdef STREAM_ARB3_LOCK_EN
        if (r_state == ST_LOCK) begin
            w_pick_vld = valid_i[r_lock_src];
            w_pick_idx = r_lock_src;
        end else
`endif
        if (valid_i[r_ptr]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = r_ptr;
        end else if (valid_i[w_cand1]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_cand1;
        end else if (valid_i[w_cand2]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = w_cand2;
        end else begin
            w_pick_vld = 1'b0;
            w_pick_idx = r_ptr;
        end
    end

    // Reset gating keeps ready_o low while the block is held in reset
    assign w_load_en = ~r_valid | ready_i;
    assign w_grant   = w_pick_vld & w_load_en & rst_ni;
    assign ready_o   = w_grant ? (3'b001 << w_pick_idx) : 3'b000;

    // Payload mux for the granted source
    always_comb begin
        case (w_pick_idx)
            2'd0:    w_data_sel = data0_i;
            2'd1:    w_data_sel = data1_i;
            default: w_data_sel = data2_i;
        endcase
    end

    // Next pointer (and lock state); ptr only moves on an unlocked grant or a burst end
    always_comb begin
        w_ptr_nxt = r_ptr;
`ifdef STREAM_ARB3_LOCK_EN
        w_state_nxt    = r_state;
        w_lock_src_nxt = r_lock_src;
        case (r_state)
            ST_ARB: begin
                if (w_grant) begin
                    w_ptr_nxt = inc3(w_pick_idx);
                    if (!last_i[w_pick_idx]) begin
                        w_state_nxt    = ST_LOCK;
                        w_lock_src_nxt = w_pick_idx;
                    end else begin
                        w_state_nxt = ST_ARB;
                    end
                end else begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_LOCK: begin
                if (w_grant && last_i[r_lock_src]) begin
                    w_state_nxt = ST_ARB;
                    w_ptr_nxt   = inc3(r_lock_src);
                end else begin
                    w_state_nxt = ST_LOCK;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
`else
        if (w_grant) begin
            w_ptr_nxt = inc3(w_pick_idx);
        end else begin
            w_ptr_nxt = r_ptr;
        end
`endif
    end

    // Arbitration state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= 2'd0;
`ifdef STREAM_ARB3_LOCK_EN
            r_state    <= ST_ARB;
            r_lock_src <= 2'd0;
`endif
        end else begin
            r_ptr <= w_ptr_nxt;
`ifdef STREAM_ARB3_LOCK_EN
            r_state    <= w_state_nxt;
            r_lock_src <= w_lock_src_nxt;
`endif
        end
    end

    // Output register: loads a granted beat, drains when nothing is granted, holds on backpressure
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 2'd0;
            r_last  <= 1'b0;
        end else if (w_load_en) begin
            if (w_grant) begin
                r_valid <= 1'b1;
                r_data  <= w_data_sel;
                r_sel   <= w_pick_idx;
                r_last  <= last_i[w_pick_idx];
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign sel_o   = r_sel;
    assign last_o  = r_last;

endmodule
